// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the memory bus arbiter: bus word, arbiter FSM states and master IDs.
package codes;

    typedef logic [31:0] size_t;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_GRANT,
        ARB_RESP
    } arb_state_t;

    typedef enum logic {
        M_INSTR = 1'b0,
        M_DATA  = 1'b1
    } arb_master_t;

endpackage

// File: rtl/mem_bus_arbiter_rr_arb2.sv
// Combinational 2-way picker: round-robin on ties, or fixed priority to the data master.
module rr_arb2
    import codes::*;
(
    input  logic [1:0]  req,
    input  arb_master_t last_grant,
    input  logic        mode,
    output arb_master_t winner
);

    always_comb begin
        winner = M_INSTR;
        case (req)
            2'b01:   winner = M_INSTR;
            2'b10:   winner = M_DATA;
            2'b11:   winner = mode ? M_DATA
                                   : ((last_grant == M_DATA) ? M_INSTR : M_DATA);
            default: winner = M_INSTR;
        endcase
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master (instruction fetch m0, data m1) to one-slave arbiter for the Avalon-style memory bus.
module mem_bus_arbiter
    import codes::*;
#(
    parameter int unsigned PRIORITY_MODE = 0
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_read,
    input  logic        m0_write,
    input  logic [3:0]  m0_byteenable,
    input  size_t       m0_address,
    input  size_t       m0_writedata,
    output logic        m0_waitrequest,
    output size_t       m0_readdata,
    output logic        m0_readdatavalid,
    input  logic        m1_read,
    input  logic        m1_write,
    input  logic [3:0]  m1_byteenable,
    input  size_t       m1_address,
    input  size_t       m1_writedata,
    output logic        m1_waitrequest,
    output size_t       m1_readdata,
    output logic        m1_readdatavalid,
    output logic        s_read,
    output logic        s_write,
    output logic [3:0]  s_byteenable,
    output size_t       s_address,
    output size_t       s_writedata,
    input  size_t       s_readdata,
    input  logic        s_waitrequest
);

    localparam logic FIXED_PRIO = (PRIORITY_MODE != 0);

    arb_state_t  state, state_next;
    arb_master_t owner, owner_next;
    arb_master_t last_grant, last_grant_next;
    arb_master_t winner;
    size_t       m0_rdata_q, m1_rdata_q;
    logic [1:0]  req;

    logic        own_read, own_write;
    logic [3:0]  own_be;
    size_t       own_address, own_writedata;

    assign req = {m1_read | m1_write, m0_read | m0_write};

    rr_arb2 u_pick (
        .req        (req),
        .last_grant (last_grant),
        .mode       (FIXED_PRIO),
        .winner     (winner)
    );

    assign own_read      = (owner == M_DATA) ? m1_read       : m0_read;
    assign own_write     = (owner == M_DATA) ? m1_write      : m0_write;
    assign own_be        = (owner == M_DATA) ? m1_byteenable : m0_byteenable;
    assign own_address   = (owner == M_DATA) ? m1_address    : m0_address;
    assign own_writedata = (owner == M_DATA) ? m1_writedata  : m0_writedata;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ARB_IDLE;
            owner      <= M_INSTR;
            last_grant <= M_DATA;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
        end else begin
            state      <= state_next;
            owner      <= owner_next;
            last_grant <= last_grant_next;
            if (m0_readdatavalid) m0_rdata_q <= s_readdata;
            if (m1_readdatavalid) m1_rdata_q <= s_readdata;
        end
    end

    // Outputs are forced to their reset values while reset is high, which also
    // suppresses a readdata pulse that would otherwise fall in that cycle.
    always_comb begin
        state_next       = state;
        owner_next       = owner;
        last_grant_next  = last_grant;
        s_read           = 1'b0;
        s_write          = 1'b0;
        s_byteenable     = '0;
        s_address        = '0;
        s_writedata      = '0;
        m0_waitrequest   = 1'b1;
        m1_waitrequest   = 1'b1;
        m0_readdatavalid = 1'b0;
        m1_readdatavalid = 1'b0;
        if (!reset) begin
            case (state)
                ARB_IDLE: begin
                    if (|req) begin
                        owner_next = winner;
                        state_next = ARB_GRANT;
                    end
                end
                ARB_GRANT: begin
                    s_read       = own_read & ~own_write;
                    s_write      = own_write;
                    s_byteenable = own_be;
                    s_address    = own_address;
                    s_writedata  = own_writedata;
                    if (owner == M_DATA) m1_waitrequest = s_waitrequest;
                    else                 m0_waitrequest = s_waitrequest;
                    if (!own_read && !own_write) begin
                        state_next = ARB_IDLE;
                    end else if (!s_waitrequest) begin
                        if (own_write) begin
                            state_next      = ARB_IDLE;
                            last_grant_next = owner;
                        end else begin
                            state_next = ARB_RESP;
                        end
                    end
                end
                ARB_RESP: begin
                    if (owner == M_DATA) m1_readdatavalid = 1'b1;
                    else                 m0_readdatavalid = 1'b1;
                    last_grant_next = owner;
                    state_next      = ARB_IDLE;
                end
                default: state_next = ARB_IDLE;
            endcase
        end
    end

    assign m0_readdata = m0_readdatavalid ? s_readdata : m0_rdata_q;
    assign m1_readdata = m1_readdatavalid ? s_readdata : m1_rdata_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(m0_read && m0_write)) else $fatal(1, "m0 read and write asserted together");
            assert (!(m1_read && m1_write)) else $fatal(1, "m1 read and write asserted together");
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: timeline model of directed and random transfers plus a fixed-priority instance.
module tb_mem_bus_arbiter;
    import codes::*;

    logic        clk;
    logic        reset;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [3:0]  m0_byteenable, m1_byteenable, s_byteenable;
    size_t       m0_address, m0_writedata, m1_address, m1_writedata;
    size_t       m0_readdata, m1_readdata, s_address, s_writedata, s_readdata;
    logic        m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
    logic        s_read, s_write, s_waitrequest;

    logic        p_m0_read, p_m0_write, p_m1_read, p_m1_write;
    logic [3:0]  p_m0_byteenable, p_m1_byteenable, p_s_byteenable;
    size_t       p_m0_address, p_m0_writedata, p_m1_address, p_m1_writedata;
    size_t       p_m0_readdata, p_m1_readdata, p_s_address, p_s_writedata, p_s_readdata;
    logic        p_m0_waitrequest, p_m1_waitrequest, p_m0_readdatavalid, p_m1_readdatavalid;
    logic        p_s_read, p_s_write, p_s_waitrequest;

    int checks   = 0;
    int failures = 0;
    int model_last;          // master that most recently completed a transfer
    size_t last_rd [2];      // value each master's readdata output must hold

    mem_bus_arbiter u_dut (
        .clk(clk), .reset(reset),
        .m0_read(m0_read), .m0_write(m0_write), .m0_byteenable(m0_byteenable),
        .m0_address(m0_address), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
        .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
        .m1_read(m1_read), .m1_write(m1_write), .m1_byteenable(m1_byteenable),
        .m1_address(m1_address), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
        .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
        .s_read(s_read), .s_write(s_write), .s_byteenable(s_byteenable),
        .s_address(s_address), .s_writedata(s_writedata),
        .s_readdata(s_readdata), .s_waitrequest(s_waitrequest)
    );

    mem_bus_arbiter #(.PRIORITY_MODE(1)) u_prio (
        .clk(clk), .reset(reset),
        .m0_read(p_m0_read), .m0_write(p_m0_write), .m0_byteenable(p_m0_byteenable),
        .m0_address(p_m0_address), .m0_writedata(p_m0_writedata), .m0_waitrequest(p_m0_waitrequest),
        .m0_readdata(p_m0_readdata), .m0_readdatavalid(p_m0_readdatavalid),
        .m1_read(p_m1_read), .m1_write(p_m1_write), .m1_byteenable(p_m1_byteenable),
        .m1_address(p_m1_address), .m1_writedata(p_m1_writedata), .m1_waitrequest(p_m1_waitrequest),
        .m1_readdata(p_m1_readdata), .m1_readdatavalid(p_m1_readdatavalid),
        .s_read(p_s_read), .s_write(p_s_write), .s_byteenable(p_s_byteenable),
        .s_address(p_s_address), .s_writedata(p_s_writedata),
        .s_readdata(p_s_readdata), .s_waitrequest(p_s_waitrequest)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " s_read"}, s_read, 0);
        chk({tag, " s_write"}, s_write, 0);
        chk({tag, " s_byteenable"}, s_byteenable, 0);
        chk({tag, " s_address"}, s_address, 0);
        chk({tag, " s_writedata"}, s_writedata, 0);
        chk({tag, " m0_waitrequest"}, m0_waitrequest, 1);
        chk({tag, " m1_waitrequest"}, m1_waitrequest, 1);
        chk({tag, " m0_readdatavalid"}, m0_readdatavalid, 0);
        chk({tag, " m1_readdatavalid"}, m1_readdatavalid, 0);
        chk({tag, " m0_readdata"}, m0_readdata, 0);
        chk({tag, " m1_readdata"}, m1_readdata, 0);
    endtask

    // Requests are presented in IDLE at cycle 0. The model lays out a timeline:
    // each grant starts one cycle after the IDLE that sees it, lasts 1+waits cycles,
    // a read adds one response cycle, then one IDLE cycle precedes the next grant.
    task automatic scenario(input bit q0, input bit q1, input bit wr0, input bit wr1,
                            input int w0, input int w1,
                            input size_t ad0, input size_t ad1, input size_t wd0, input size_t wd1,
                            input size_t rd0, input size_t rd1,
                            input logic [3:0] b0, input logic [3:0] b1);
        bit q [2], wr [2], act [2];
        int w [2], t [2], acc [2], resp [2], ord [2];
        size_t ad [2], wd [2], rd [2];
        logic [3:0] b [2];
        int n, start, idle, total, g;
        logic e_read, e_write;
        logic [3:0] e_be;
        size_t e_addr, e_wd;
        logic o_wait [2], o_val [2];
        size_t o_rd [2];
        q[0] = q0; q[1] = q1; wr[0] = wr0; wr[1] = wr1; w[0] = w0; w[1] = w1;
        ad[0] = ad0; ad[1] = ad1; wd[0] = wd0; wd[1] = wd1; rd[0] = rd0; rd[1] = rd1;
        b[0] = b0; b[1] = b1;
        for (int m = 0; m < 2; m++) begin t[m] = -1; acc[m] = -1; resp[m] = -1; end
        if (q0 && q1) begin
            ord[0] = (model_last == 1) ? 0 : 1;
            ord[1] = 1 - ord[0];
            n = 2;
        end else begin
            ord[0] = q0 ? 0 : 1;
            ord[1] = 0;
            n = 1;
        end
        start = 1;
        idle  = 0;
        for (int k = 0; k < n; k++) begin
            t[ord[k]]   = start;
            acc[ord[k]] = start + w[ord[k]];
            if (wr[ord[k]]) idle = acc[ord[k]] + 1;
            else begin
                resp[ord[k]] = acc[ord[k]] + 1;
                idle         = acc[ord[k]] + 2;
            end
            start = idle + 1;
        end
        total      = idle;
        model_last = ord[n-1];

        for (int c = 0; c <= total; c++) begin
            for (int m = 0; m < 2; m++) act[m] = q[m] && (c <= acc[m]);
            m0_read = act[0] && !wr[0]; m0_write = act[0] && wr[0];
            m1_read = act[1] && !wr[1]; m1_write = act[1] && wr[1];
            m0_address = ad[0]; m0_writedata = wd[0]; m0_byteenable = b[0];
            m1_address = ad[1]; m1_writedata = wd[1]; m1_byteenable = b[1];
            g = -1;
            for (int m = 0; m < 2; m++) if (q[m] && c >= t[m] && c <= acc[m]) g = m;
            s_waitrequest = (g >= 0) && (c < acc[(g >= 0) ? g : 0]);
            s_readdata = $urandom;
            for (int m = 0; m < 2; m++) if (q[m] && !wr[m] && c == resp[m]) s_readdata = rd[m];
            e_read = 0; e_write = 0; e_be = '0; e_addr = '0; e_wd = '0;
            if (g >= 0) begin
                e_read = !wr[g]; e_write = wr[g]; e_be = b[g]; e_addr = ad[g]; e_wd = wd[g];
            end
            #1;
            chk($sformatf("s_read c%0d", c), s_read, e_read);
            chk($sformatf("s_write c%0d", c), s_write, e_write);
            chk($sformatf("s_byteenable c%0d", c), s_byteenable, e_be);
            chk($sformatf("s_address c%0d", c), s_address, e_addr);
            chk($sformatf("s_writedata c%0d", c), s_writedata, e_wd);
            o_wait[0] = m0_waitrequest;   o_wait[1] = m1_waitrequest;
            o_val[0]  = m0_readdatavalid; o_val[1]  = m1_readdatavalid;
            o_rd[0]   = m0_readdata;      o_rd[1]   = m1_readdata;
            for (int m = 0; m < 2; m++) begin
                bit ev;
                ev = q[m] && !wr[m] && (c == resp[m]);
                chk($sformatf("m%0d_waitrequest c%0d", m, c), o_wait[m], !(g == m && c == acc[m]));
                chk($sformatf("m%0d_readdatavalid c%0d", m, c), o_val[m], ev);
                if (ev) last_rd[m] = rd[m];
                chk($sformatf("m%0d_readdata c%0d", m, c), o_rd[m], last_rd[m]);
            end
            tick();
        end
    endtask

    initial begin
        size_t pa0, pa1, prd, plast1;
        reset = 1'b1;
        m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
        m0_byteenable = '0; m1_byteenable = '0;
        m0_address = '0; m0_writedata = '0; m1_address = '0; m1_writedata = '0;
        s_readdata = '0; s_waitrequest = 1'b0;
        p_m0_read = 0; p_m0_write = 0; p_m1_read = 0; p_m1_write = 0;
        p_m0_byteenable = 4'hF; p_m1_byteenable = 4'hF;
        p_m0_address = '0; p_m0_writedata = '0; p_m1_address = '0; p_m1_writedata = '0;
        p_s_readdata = '0; p_s_waitrequest = 1'b0;
        model_last = 1;
        last_rd[0] = '0; last_rd[1] = '0;

        tick(); tick();
        reset = 1'b0;
        #1;
        chk_reset_outputs("after_reset");
        chk("prio after_reset m0_waitrequest", p_m0_waitrequest, 1);
        chk("prio after_reset m1_readdata", p_m1_readdata, 0);
        tick();

        // tie from reset: m0 read vs m1 write, m0 must win
        scenario(1, 1, 0, 1, 0, 0, 32'hBFC00000, 32'hBFC00100, '0, 32'hDEADBEEF,
                 32'h3C011234, '0, 4'hF, 4'b0011);
        // single m0 fetch, zero wait
        scenario(1, 0, 0, 0, 0, 0, 32'hBFC00000, '0, '0, '0, 32'h3C011234, '0, 4'hF, 4'h0);
        // same tie again, last served was m0 so m1 goes first
        scenario(1, 1, 0, 1, 0, 0, 32'hBFC00004, 32'hBFC00100, '0, 32'hDEADBEEF,
                 32'h8C220000, '0, 4'hF, 4'b0011);
        // m1 read with three slave wait cycles
        scenario(0, 1, 0, 0, 0, 3, '0, 32'h80001000, '0, '0, '0, 32'hCAFEF00D, 4'h0, 4'hF);

        // reset during the response cycle of an m0 read
        m0_read = 1; m0_address = 32'hBFC00010; m0_byteenable = 4'hF; s_waitrequest = 0;
        #1;
        tick();
        #1;
        chk("rst_resp grant s_read", s_read, 1);
        tick();
        m0_read = 0; reset = 1'b1; s_readdata = 32'h12345678;
        #1;
        chk("rst_resp m0_readdatavalid", m0_readdatavalid, 0);
        tick();
        reset = 1'b0;
        #1;
        chk_reset_outputs("rst_resp next");
        model_last = 1;
        last_rd[0] = '0; last_rd[1] = '0;
        tick();
        // last_grant is back to m1, so m0 wins this tie
        scenario(1, 1, 0, 0, 1, 0, 32'h00400000, 32'h10010000, '0, '0,
                 32'h01234567, 32'h89ABCDEF, 4'hF, 4'hF);

        repeat (24) begin
            int sel;
            sel = int'($urandom_range(1, 3));
            scenario(sel[0], sel[1], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                     $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                     4'($urandom), 4'($urandom));
        end

        // fixed priority: both masters read continuously, m1 must own every grant
        pa0 = $urandom; pa1 = $urandom; plast1 = '0;
        p_m0_address = pa0; p_m1_address = pa1;
        p_m0_read = 1; p_m1_read = 1;
        for (int c = 0; c < 12; c++) begin
            prd = $urandom;
            p_s_readdata = prd;
            #1;
            chk($sformatf("prio s_read c%0d", c), p_s_read, (c % 3) == 1);
            chk($sformatf("prio s_address c%0d", c), p_s_address, ((c % 3) == 1) ? pa1 : '0);
            chk($sformatf("prio m0_waitrequest c%0d", c), p_m0_waitrequest, 1);
            chk($sformatf("prio m1_readdatavalid c%0d", c), p_m1_readdatavalid, (c % 3) == 2);
            if ((c % 3) == 2) plast1 = prd;
            chk($sformatf("prio m1_readdata c%0d", c), p_m1_readdata, plast1);
            tick();
        end
        p_m1_read = 0;
        #1;
        chk("prio idle s_read", p_s_read, 0);
        tick();
        #1;
        chk("prio m0 grant s_address", p_s_address, pa0);
        chk("prio m0 grant waitrequest", p_m0_waitrequest, 0);
        tick();
        p_m0_read = 0;
        prd = $urandom;
        p_s_readdata = prd;
        #1;
        chk("prio m0 readdatavalid", p_m0_readdatavalid, 1);
        chk("prio m0 readdata", p_m0_readdata, prd);
        tick();
        #1;
        chk("prio m0 readdata hold", p_m0_readdata, prd);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
